// File: rtl/ddr_axi_rd_master.sv
`timescale 1ns/1ps
// AXI4 read master: splits one user request into INCR bursts (<= MAX_BURST beats, no 4 KB crossing).
// Optional DDR_RD_STAT_EN adds rd_beat_total / rd_err_cnt statistics outputs.
module ddr_axi_rd_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 29,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 256,
  parameter int ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] RD_ID = 'hF
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  rd_start,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_start_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_fifo_data,
  output logic                  rd_fifo_we,
  input  logic                  rd_fifo_full,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rlast,
  input  logic [1:0]            m_axi_rresp,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  output logic                  m_axi_rready
`ifdef DDR_RD_STAT_EN
  ,
  output logic [31:0]           rd_beat_total,
  output logic [15:0]           rd_err_cnt
`endif
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

  state_t               state_reg;
  logic [LEN_WIDTH-1:0] remain_reg;
  logic [8:0]           beats_reg;
  logic [8:0]           beat_cnt_reg;

  logic                  beat_ok;
  logic                  beat_err;
  logic                  last_exp;
  logic [LEN_WIDTH-1:0]  remain_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [8:0]            beats_start;
  logic [8:0]            beats_next;

  // Beats for one burst: limited by what is left, MAX_BURST and the distance to the next 4 KB page.
  function automatic logic [8:0] calc_beats(input logic [11:0] off, input logic [LEN_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [31:0] m;
    room = (13'd4096 - {1'b0, off}) >> SZ;
    m = 32'(MAX_BURST);
    if (32'(rem) < m) m = 32'(rem);
    if (32'(room) < m) m = 32'(room);
    return m[8:0];
  endfunction

  assign start_addr  = rd_start_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign remain_next = remain_reg - LEN_WIDTH'(beats_reg);
  assign addr_next   = m_axi_araddr + (ADDR_WIDTH'(beats_reg) << SZ);
  assign beats_start = calc_beats(start_addr[11:0], rd_len);
  assign beats_next  = calc_beats(addr_next[11:0], remain_next);

  assign rd_ready     = (state_reg == IDLE);
  assign m_axi_rready = (state_reg == DATA) && !rd_fifo_full;
  assign beat_ok      = m_axi_rvalid && m_axi_rready;
  assign rd_fifo_we   = beat_ok;
  assign rd_fifo_data = m_axi_rdata;

  // rlast mismatch covers both an early rlast and a missing one on the expected last beat.
  assign last_exp = (beat_cnt_reg == beats_reg - 9'd1);
  assign beat_err = (m_axi_rresp != 2'b00) || (m_axi_rid != RD_ID) || (m_axi_rlast != last_exp);

  assign m_axi_arid    = RD_ID;
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg     <= IDLE;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      rd_done       <= 1'b0;
      rd_err        <= 1'b0;
      remain_reg    <= '0;
      beats_reg     <= '0;
      beat_cnt_reg  <= '0;
    end else begin
      rd_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd_start && (rd_len != '0)) begin
            m_axi_araddr  <= start_addr;
            remain_reg    <= rd_len;
            beats_reg     <= beats_start;
            m_axi_arlen   <= 8'(beats_start - 9'd1);
            m_axi_arvalid <= 1'b1;
            rd_err        <= 1'b0;
            state_reg     <= AR;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            beat_cnt_reg  <= '0;
            state_reg     <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            beat_cnt_reg <= beat_cnt_reg + 9'd1;
            if (beat_err) rd_err <= 1'b1;
            if (m_axi_rlast) begin
              remain_reg   <= remain_next;
              m_axi_araddr <= addr_next;
              if (remain_next == '0) begin
                rd_done   <= 1'b1;
                state_reg <= DONE;
              end else begin
                beats_reg     <= beats_next;
                m_axi_arlen   <= 8'(beats_next - 9'd1);
                m_axi_arvalid <= 1'b1;
                state_reg     <= AR;
              end
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DDR_RD_STAT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_beat_total <= '0;
      rd_err_cnt    <= '0;
    end else begin
      if (beat_ok) rd_beat_total <= rd_beat_total + 32'd1;
      if (rd_done && rd_err && (rd_err_cnt != 16'hFFFF)) rd_err_cnt <= rd_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ddr_axi_rd_master.md
Name: ddr_axi_rd_master

Overview:
Parametrised AXI4 read master: successor to the single-burst DDR read engine. Accepts one user read request of up to 2^LEN_WIDTH-1 beats and splits it into legal AXI4 INCR bursts, each limited by MAX_BURST and never crossing a 4 KB boundary. Streams returned data into the UI read FIFO with backpressure from FIFO full. Checks RRESP, RID and RLAST, and reports a sticky per-request error with the done pulse.

Parameters:
DATA_WIDTH, 64, AXI data width in bits; power of two, 32..512; BYTES = DATA_WIDTH/8, SZ = log2(BYTES).
ADDR_WIDTH, 29, AXI byte-address width.
LEN_WIDTH, 16, width of the user request length in beats.
MAX_BURST, 256, maximum beats per AXI burst; 1..256.
ID_WIDTH, 4, AXI ID width.
RD_ID, 4'hF, constant ARID; RID is checked against it.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
rd_start  in  1  request strobe; sampled only when rd_ready=1
rd_len  in  LEN_WIDTH  total beats; 0 = request ignored
rd_start_addr  in  ADDR_WIDTH  byte address; low SZ bits forced to 0
rd_ready  out  1  idle, request accepted
rd_fifo_data  out  DATA_WIDTH  = m_axi_rdata
rd_fifo_we  out  1  = m_axi_rvalid & m_axi_rready
rd_fifo_full  in  1  FIFO cannot take data this cycle
rd_done  out  1  one-cycle pulse at request end
rd_err  out  1  error status, valid while rd_done=1
m_axi_arid  out  ID_WIDTH  = RD_ID
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  = SZ
m_axi_arburst  out  2  = 2'b01
m_axi_arlock/arcache/arprot/arqos  out  1/4/3/4  = 0 / 4'b0011 / 0 / 0
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address accepted
m_axi_rvalid/rlast/rresp/rid/rdata  in  1/1/2/ID_WIDTH/DATA_WIDTH  read data channel
m_axi_rready  out  1  = (state==DATA) & ~rd_fifo_full

Behaviour:
- Reset: state IDLE, arvalid=0, araddr=0, arlen=0, rd_done=0, rd_err=0, rready=0; rd_ready=1 after reset release.
- States: IDLE, AR, DATA, DONE. rd_ready = (state==IDLE).
- IDLE:
  - rd_start & rd_len!=0: latch addr (low SZ bits zeroed) and remain=rd_len, clear error, go to AR.
  - rd_start with rd_len==0: no state change, no rd_done.
- Burst size, registered on entry to AR: beats = min(remain, MAX_BURST, (4096 - addr[11:0]) >> SZ); arlen = beats-1. Arithmetic is 13 bits wide for the boundary term.
- AR: arvalid=1 from the first AR cycle; araddr and arlen held stable until arready. Handshake then clears arvalid and moves to DATA. First arvalid appears 1 cycle after the accepted rd_start.
- DATA:
  - Each accepted beat increments beat_cnt; rd_fifo_we is asserted combinationally on the same cycle.
  - The burst ends on the accepted beat with rlast=1.
  - At burst end: remain -= beats, addr += beats<<SZ.
  - remain==0: go to DONE. Otherwise go to AR; the next arvalid follows 1 cycle later. Only one burst is outstanding at a time.
- Errors (all sticky until the next accepted request):
  - rresp!=2'b00 on any accepted beat.
  - rid!=RD_ID.
  - rlast on a beat other than beat_cnt==beats-1.
  - Missing rlast on the expected last beat: set the error, keep accepting until rlast.
- DONE: rd_done=1 for exactly one cycle with rd_err valid, then IDLE. rd_err holds its value until the next accepted start.
- Backpressure: rd_fifo_full=1 drops rready that same cycle. No beat is written while full.
- rd_start outside IDLE is ignored.
- Asynchronous reset mid-burst aborts immediately to the reset state. Outstanding slave data is not drained; the system resets the slave together with the master.

Optional Feature:
DDR_RD_STAT_EN. When defined, adds two outputs:
- rd_beat_total [31:0]: free-running count of accepted beats; wraps at 2^32.
- rd_err_cnt [15:0]: count of requests ending with rd_err=1; saturates at 16'hFFFF.
Both reset to 0. When the macro is undefined, these ports and their counters are absent and all other behaviour is identical.

Test Plan:
- addr 0x100, rd_len=16, DATA_WIDTH=64 -> one burst, araddr=0x100, arlen=15, arsize=3; 16 fifo writes; rd_done 1 cycle after the rlast beat; rd_err=0.
- addr 0x0, rd_len=300, MAX_BURST=256 -> bursts (0x0, arlen 255) then (0x800, arlen 43); 300 writes; single rd_done.
- addr 0xFC0, rd_len=16 -> bursts (0xFC0, arlen 7) then (0x1000, arlen 7); no 4 KB crossing.
- rd_fifo_full toggled every other cycle during a 32-beat burst -> rready low whenever full; exactly 32 writes; data order preserved.
- beat 5 returns rresp=2'b10, or rlast arrives early on beat 3 of 8 -> rd_done with rd_err=1; next clean request ends with rd_err=0.
- ARESETN asserted mid-DATA -> arvalid=0, rready=0, rd_ready=1 after release; a new request completes normally.
